// File: rtl/atm_input_frontend_if.sv
// Input-side bundle of the ATM front end: raw buttons, keypad, PIN data and the conditioned controller inputs.
// master drives the raw side and reads the conditioned side; slave is the front end itself.
interface atm_input_frontend_if #(
    parameter int PIN_DIGITS = 4,
    parameter int DIGIT_W    = 4
);
    logic                          btn_back;
    logic                          btn_enter;
    logic                          key_strobe;
    logic [DIGIT_W-1:0]            key_digit;
    logic [1:0]                    opt_sel;
    logic [PIN_DIGITS*DIGIT_W-1:0] stored_pin;
    logic                          pin_clear;
    logic                          B;
    logic                          E;
    logic                          V;
    logic                          O2;
    logic                          O1;
    logic [2:0]                    digit_count;
    logic                          locked;

    modport master (
        output btn_back, btn_enter, key_strobe, key_digit, opt_sel, stored_pin, pin_clear,
        input  B, E, V, O2, O1, digit_count, locked
    );

    modport slave (
        input  btn_back, btn_enter, key_strobe, key_digit, opt_sel, stored_pin, pin_clear,
        output B, E, V, O2, O1, digit_count, locked
    );
endinterface

// File: rtl/atm_input_frontend.sv
// ATM input front end: sync/debounce of buttons, keypad and options, PIN collect/check, B/E/V/O2/O1 outputs.
// Latency: raw press to B/E pulse DEBOUNCE_CYCLES+3 clk, V two clk after E; no backpressure, inputs are free-running.
module atm_input_frontend #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PIN_DIGITS      = 4,
    parameter int DIGIT_W         = 4,
    parameter int MAX_TRIES       = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    atm_input_frontend_if.slave  bus
);

    localparam int NB = 5;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = PIN_DIGITS * DIGIT_W;
    localparam int TW = $clog2(MAX_TRIES + 1);

    // Bit map of the conditioned vector: 4 back, 3 enter, 2 strobe, 1:0 options.
    localparam int I_BACK   = 4;
    localparam int I_ENTER  = 3;
    localparam int I_STROBE = 2;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CHECK   = 2'd1,
        PASS    = 2'd2,
        LOCK    = 2'd3
    } state_t;

    logic [NB-1:0]      raw;
    logic [NB-1:0]      sync1;
    logic [NB-1:0]      sync2;
    logic [NB-1:0]      deb;
    logic [CW-1:0]      cnt [NB];
    logic [2:0]         deb_d;
    logic [DIGIT_W-1:0] dig1;
    logic [DIGIT_W-1:0] dig2;

    logic ev_back;
    logic ev_enter;
    logic ev_strobe;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] pin_buf;
    logic [2:0]    count;
    logic [TW-1:0] tries;
    logic [TW-1:0] tries_inc;
    logic          pin_match;
    logic          clr_req;

    logic do_clear;
    logic do_shift;
    logic do_fail;
    logic v_nxt;
    logic locked_nxt;

    logic       back_pulse;
    logic       enter_pulse;
    logic       v_lvl;
    logic       locked_lvl;
    logic [1:0] opt_lat;

    assign raw = {bus.btn_back, bus.btn_enter, bus.key_strobe, bus.opt_sel};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            dig1  <= '0;
            dig2  <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            dig1  <= bus.key_digit;
            dig2  <= dig1;
        end
    end

    // A level is accepted only after DEBOUNCE_CYCLES unbroken mismatching samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NB; i++) cnt[i] <= '0;
            deb <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_d     <= '0;
            ev_back   <= 1'b0;
            ev_enter  <= 1'b0;
            ev_strobe <= 1'b0;
        end else begin
            deb_d     <= deb[I_BACK:I_STROBE];
            ev_back   <= deb[I_BACK]   & ~deb_d[2];
            ev_enter  <= deb[I_ENTER]  & ~deb_d[1];
            ev_strobe <= deb[I_STROBE] & ~deb_d[0];
        end
    end

    // Back and pin_clear share one internal clear path; back also wins over enter.
    assign clr_req   = ev_back | bus.pin_clear;
    assign pin_match = (count == 3'(PIN_DIGITS)) && (pin_buf == bus.stored_pin);
    assign tries_inc = (tries == TW'(MAX_TRIES)) ? tries : tries + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: begin
                if (clr_req)       state_nxt = COLLECT;
                else if (ev_enter) state_nxt = CHECK;
            end
            CHECK: begin
                if (pin_match)                         state_nxt = PASS;
                else if (tries_inc == TW'(MAX_TRIES))  state_nxt = LOCK;
                else                                   state_nxt = COLLECT;
            end
            PASS: begin
                if (clr_req) state_nxt = COLLECT;
            end
            LOCK:    state_nxt = LOCK;
            default: state_nxt = COLLECT;
        endcase
    end

    always_comb begin
        do_clear   = 1'b0;
        do_shift   = 1'b0;
        do_fail    = 1'b0;
        v_nxt      = 1'b0;
        locked_nxt = 1'b0;
        case (state)
            COLLECT: begin
                do_clear = clr_req;
                // A digit arriving with enter is dropped: the check sees the buffer as it was.
                do_shift = !clr_req && !ev_enter && ev_strobe && (count < 3'(PIN_DIGITS));
            end
            CHECK: begin
                do_fail = !pin_match;
            end
            PASS: begin
                do_clear = clr_req;
                v_nxt    = !clr_req;
            end
            LOCK: begin
                locked_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_buf <= '0;
            count   <= '0;
            tries   <= '0;
        end else begin
            if (do_clear || do_fail) begin
                pin_buf <= '0;
                count   <= '0;
            end else if (do_shift) begin
                pin_buf <= {pin_buf[PW-DIGIT_W-1:0], dig2};
                count   <= count + 3'd1;
            end
            if (do_fail) tries <= tries_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            back_pulse  <= 1'b0;
            enter_pulse <= 1'b0;
            v_lvl       <= 1'b0;
            locked_lvl  <= 1'b0;
            opt_lat     <= '0;
        end else begin
            back_pulse  <= ev_back;
            enter_pulse <= ev_enter & ~ev_back;
            v_lvl       <= v_nxt;
            locked_lvl  <= locked_nxt;
            if (ev_enter && !ev_back) opt_lat <= deb[1:0];
        end
    end

    assign bus.B           = back_pulse;
    assign bus.E           = enter_pulse;
    assign bus.V           = v_lvl;
    assign bus.O2          = opt_lat[1];
    assign bus.O1          = opt_lat[0];
    assign bus.digit_count = count;
    assign bus.locked      = locked_lvl;

endmodule

// File: tb/tb_atm_input_frontend.sv
// Directed bench for atm_input_frontend: B/E pulses are scoreboarded with their expected cycle and option bits,
// levels (V, digit_count, locked, O2/O1) are checked directly at fixed points of the sequence.
module tb_atm_input_frontend;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cyc = 32'd0;
    int          checks = 0;
    int          errors = 0;
    int          e_seen = 0;

    typedef struct packed {
        logic        b;
        logic        e;
        logic        o2;
        logic        o1;
        logic [31:0] at;
    } ev_t;

    ev_t sb[$];
    ev_t mon_got;
    ev_t mon_want;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    atm_input_frontend_if #(.PIN_DIGITS(4), .DIGIT_W(4)) bus ();

    atm_input_frontend #(
        .DEBOUNCE_CYCLES(4),
        .PIN_DIGITS(4),
        .DIGIT_W(4),
        .MAX_TRIES(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Every B/E pulse must match the oldest expected pulse, including its cycle.
    always @(negedge clk) begin
        if (rst_n && (bus.B || bus.E)) begin
            if (bus.E) e_seen++;
            mon_got.b  = bus.B;
            mon_got.e  = bus.E;
            mon_got.o2 = bus.O2;
            mon_got.o1 = bus.O1;
            mon_got.at = cyc;
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_pulse got B=%0b E=%0b at cycle %0d, required no pulse",
                       bus.B, bus.E, cyc);
            end
            if (sb.size() != 0) begin
                mon_want = sb.pop_front();
                assert (mon_got === mon_want) else begin
                    errors++;
                    $error("FAIL pulse got B=%0b E=%0b O2=%0b O1=%0b cyc=%0d required B=%0b E=%0b O2=%0b O1=%0b cyc=%0d",
                           mon_got.b, mon_got.e, mon_got.o2, mon_got.o1, mon_got.at,
                           mon_want.b, mon_want.e, mon_want.o2, mon_want.o1, mon_want.at);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // A raw level first sampled at edge cyc+1 yields its pulse at edge cyc+8 (DEBOUNCE_CYCLES+3 later).
    task automatic expect_pulse(input logic b, input logic e, input logic o2, input logic o1);
        ev_t x;
        x.b  = b;
        x.e  = e;
        x.o2 = o2;
        x.o1 = o1;
        x.at = cyc + 32'd8;
        sb.push_back(x);
    endtask

    task automatic key(input logic [3:0] d);
        bus.key_digit  = d;
        bus.key_strobe = 1'b1;
        tick(8);
        bus.key_strobe = 1'b0;
        tick(8);
    endtask

    task automatic press_enter(input logic o2, input logic o1);
        expect_pulse(1'b0, 1'b1, o2, o1);
        bus.btn_enter = 1'b1;
        tick(8);
        bus.btn_enter = 1'b0;
        tick(8);
    endtask

    task automatic press_back(input logic o2, input logic o1);
        expect_pulse(1'b1, 1'b0, o2, o1);
        bus.btn_back = 1'b1;
        tick(8);
        bus.btn_back = 1'b0;
        tick(8);
    endtask

    task automatic do_reset();
        bus.btn_back   = 1'b0;
        bus.btn_enter  = 1'b0;
        bus.key_strobe = 1'b0;
        bus.key_digit  = 4'd0;
        bus.opt_sel    = 2'b00;
        bus.pin_clear  = 1'b0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        bus.btn_back   = 1'b0;
        bus.btn_enter  = 1'b0;
        bus.key_strobe = 1'b0;
        bus.key_digit  = 4'd0;
        bus.opt_sel    = 2'b00;
        bus.pin_clear  = 1'b0;
        bus.stored_pin = 16'h1234;
        rst_n = 1'b0;
        tick(3);
        check("reset_outputs", {25'd0, bus.B, bus.E, bus.V, bus.O2, bus.O1, bus.digit_count, bus.locked}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Chatter shorter than the debounce window never pulses.
        bus.btn_enter = 1'b1; tick(1);
        bus.btn_enter = 1'b0; tick(1);
        bus.btn_enter = 1'b1; tick(1);
        bus.btn_enter = 1'b0; tick(1);
        bus.btn_enter = 1'b1; tick(1);
        bus.btn_enter = 1'b0; tick(12);
        check("chatter_no_e", e_seen, 0);

        expect_pulse(1'b0, 1'b1, 1'b0, 1'b0);
        bus.btn_enter = 1'b1;
        tick(10);
        bus.btn_enter = 1'b0;
        tick(10);
        check("held_one_e", e_seen, 1);

        // Reset in the middle of a debounce: the held button must requalify from scratch.
        bus.btn_enter = 1'b1;
        tick(4);
        rst_n = 1'b0;
        tick(1);
        check("mid_reset_e_low", {31'd0, bus.E}, 32'd0);
        rst_n = 1'b1;
        expect_pulse(1'b0, 1'b1, 1'b0, 1'b0);
        tick(10);
        bus.btn_enter = 1'b0;
        tick(10);
        check("post_reset_one_e", e_seen, 2);

        // Correct PIN.
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            key(4'(i));
            check("count_step", bus.digit_count, 32'(i));
        end
        expect_pulse(1'b0, 1'b1, 1'b0, 1'b0);
        bus.btn_enter = 1'b1;
        tick(9);
        check("v_not_yet", bus.V, 1'b0);
        tick(1);
        check("v_rise", bus.V, 1'b1);
        bus.btn_enter = 1'b0;
        tick(10);
        key(4'd5);
        check("fifth_key_count", bus.digit_count, 32'd4);
        bus.pin_clear = 1'b1;
        tick(1);
        bus.pin_clear = 1'b0;
        tick(3);
        check("clear_v", bus.V, 1'b0);
        check("clear_count", bus.digit_count, 32'd0);

        // Three wrong PINs lock the card until reset.
        do_reset();
        for (int a = 1; a <= 3; a++) begin
            key(4'd1); key(4'd2); key(4'd3); key(4'd5);
            press_enter(1'b0, 1'b0);
            check("fail_count", bus.digit_count, 32'd0);
            check("fail_v", bus.V, 1'b0);
            check("fail_locked", bus.locked, (a == 3) ? 32'd1 : 32'd0);
        end
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        check("lock_ignores_keys", bus.digit_count, 32'd0);
        press_enter(1'b0, 1'b0);
        check("lock_v", bus.V, 1'b0);
        check("lock_held", bus.locked, 1'b1);
        do_reset();
        check("lock_cleared", bus.locked, 1'b0);

        // Short PIN fails; back keeps tries but clears the buffer.
        do_reset();
        key(4'd1); key(4'd2);
        press_enter(1'b0, 1'b0);
        check("short_count", bus.digit_count, 32'd0);
        check("short_v", bus.V, 1'b0);
        key(4'd1);
        check("pre_back_count", bus.digit_count, 32'd1);
        press_back(1'b0, 1'b0);
        check("back_count", bus.digit_count, 32'd0);
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        press_enter(1'b0, 1'b0);
        check("retry_v", bus.V, 1'b1);

        // Back and enter together; options latch only on an accepted enter.
        do_reset();
        bus.opt_sel = 2'b10;
        key(4'd1);
        check("pre_both_count", bus.digit_count, 32'd1);
        expect_pulse(1'b1, 1'b0, 1'b0, 1'b0);
        bus.btn_back  = 1'b1;
        bus.btn_enter = 1'b1;
        tick(8);
        bus.btn_back  = 1'b0;
        bus.btn_enter = 1'b0;
        tick(8);
        check("both_count", bus.digit_count, 32'd0);
        check("both_v", bus.V, 1'b0);
        press_enter(1'b1, 1'b0);
        check("opt_latched", {30'd0, bus.O2, bus.O1}, 32'd2);
        bus.opt_sel = 2'b01;
        tick(12);
        check("opt_held", {30'd0, bus.O2, bus.O1}, 32'd2);
        press_enter(1'b0, 1'b1);
        check("opt_reloaded", {30'd0, bus.O2, bus.O1}, 32'd1);

        tick(4);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/atm_input_frontend.md
Name: atm_input_frontend

Overview:
Front-end input stage of the ATM controller. It conditions raw button and keypad signals, collects and checks the customer PIN, and produces the B, E, V, O2 and O1 inputs consumed by the next-state logic, with S2..S0 fed back from the state register. All outputs are registered, glitch-free and synchronous to clk.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronized cycles a raw input must hold a new level before it is accepted (min 2)
PIN_DIGITS, 4, digits in a PIN
DIGIT_W, 4, bits per keypad digit (BCD)
MAX_TRIES, 3, failed PIN checks before lockout

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock, asynchronous assert, active-low
btn_back  in  1  raw asynchronous "back/cancel" button, active-high
btn_enter  in  1  raw asynchronous "enter" button, active-high
key_strobe  in  1  raw asynchronous keypad digit-press strobe, active-high
key_digit  in  DIGIT_W  raw keypad digit, stable while key_strobe is high
opt_sel  in  2  raw menu option switches {opt2,opt1}
stored_pin  in  PIN_DIGITS*DIGIT_W  account PIN, first digit in MSBs, static per session
pin_clear  in  1  synchronous pulse from controller: start new PIN session
B  out  1  one-cycle back pulse
E  out  1  one-cycle enter pulse
V  out  1  PIN verified level
O2  out  1  latched option bit 2
O1  out  1  latched option bit 1
digit_count  out  3  digits currently buffered (0..PIN_DIGITS)
locked  out  1  card locked after MAX_TRIES failures

Behaviour:
- Reset (rst_n=0, async): every flop clears. B=E=V=O2=O1=0, digit_count=0, locked=0, tries=0, PIN FSM=COLLECT, debounced levels=0.
- Conditioning: btn_back, btn_enter, key_strobe and opt_sel each pass through a 2-FF synchronizer. key_digit is captured by a 2-FF synchronizer in parallel with key_strobe.
- Debounce: each synchronized bit has its own counter. The debounced level takes the synchronized value after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any mismatch break resets that counter to 0.
- Edge detect: a one-cycle pulse is produced on each debounced 0->1 transition of back, enter and strobe. Latency from the first clk edge sampling the raw high level to the output pulse is DEBOUNCE_CYCLES+3 cycles. Release generates no pulse.
- O2/O1: loaded from the debounced opt_sel in the same cycle the enter pulse is produced, and held otherwise.
- PIN FSM states:
  - COLLECT: on a strobe pulse, if digit_count<PIN_DIGITS, shift the synchronized digit into the buffer LSB side and increment digit_count. When digit_count==PIN_DIGITS, extra digits are ignored.
  - CHECK: entered from COLLECT on an enter pulse. Lasts one cycle and compares the buffer with stored_pin only if digit_count==PIN_DIGITS; fewer digits counts as a mismatch. A match goes to PASS. A mismatch increments tries, clears the buffer and count, then goes to LOCK if tries reaches MAX_TRIES, else to COLLECT.
  - PASS: V=1, digits ignored. Stays until pin_clear.
  - LOCK: locked=1, V=0, digits and enter pulses ignored by the FSM. Exit only by rst_n.
- V rises 2 cycles after the E pulse (CHECK cycle, then registered). E itself is emitted in every state so the controller sees it.
- B pulse, in COLLECT or PASS: clears buffer, digit_count and V, and goes to COLLECT. tries is kept. In LOCK, B is passed to the output only.
- pin_clear: same as B internally, without producing a B output pulse. In LOCK it is ignored.
- Simultaneous events:
  - back and enter pulses in the same cycle: B is emitted, E is suppressed, no check.
  - enter and strobe in the same cycle: the check uses the buffer before the digit, and the digit is discarded.
  - pin_clear in the same cycle as enter: pin_clear wins, no check.
- tries saturates at MAX_TRIES and never wraps.
- Reset mid-check or mid-debounce: all state is dropped. A held button after reset release must re-satisfy the full debounce window before it pulses.

Test Plan:
- After reset, with btn_enter high 1 cycle and a 3-cycle chatter, then low: no E pulse. Then btn_enter held 10 cycles: exactly one E pulse, 7 cycles after the first sampled high edge (DEBOUNCE_CYCLES=4).
- stored_pin=16'h1234, keys 1,2,3,4, then enter: digit_count steps 1..4, E pulses, V=1 two cycles later. A fifth key leaves digit_count=4. pin_clear then gives V=0 and digit_count=0.
- Keys 1,2,3,5 then enter, three times: after each attempt digit_count=0 and V=0. After the third, locked=1; keys 1,2,3,4 plus enter give V=0 and locked=1 until rst_n.
- Keys 1,2 then enter: mismatch, tries=1. Back pulse, then 1,2,3,4 and enter: V=1 (tries not reset).
- btn_back and btn_enter raised on the same clk edge: B pulses, E stays 0, digit_count=0. With opt_sel=2'b10 at an accepted enter: O2=1 and O1=0, held after opt_sel changes to 2'b01 until the next enter.
